// File: rtl/adc_acq_ctrl.sv
// ---------------------------------------------------------------------------
// adc_acq_ctrl
//   Acquisition sequencer for the AD9265 capture path.
//   This block enables the ADC interface and discards samples while the
//   front end settles. It then forwards exactly acq_len samples, or streams
//   continuously when acq_len is 0, to a valid/ready output with a last
//   marker. It also reports done, timeout and overflow status to the host.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   adc_init          ADC SPI configuration complete
//   acq_start         single-cycle start request (IDLE only)
//   acq_abort         single-cycle abort request (ARM/RUN only)
//   acq_len           samples per capture, 0 = continuous (latched on start)
//   acq_test          test-pattern mode (latched on start)
//   adc_start         capture enable to the ADC interface
//   adc_test          test-pattern select to the ADC interface
//   adc_data_in       sample from the ADC interface FIFO
//   adc_data_en_in    sample valid
//   m_data/m_valid/m_last/m_ready   output sample stream
//   busy              sequencer not idle
//   done              one-cycle pulse when returning to IDLE from STOP
//   err_timeout       sticky: no sample for TIMEOUT_CYCLES, or adc_init lost
//   err_overflow      sticky: a sample arrived while the output was stalled
//   sample_count      samples forwarded in the current/last capture
//   state_dbg         current sequencer state (IDLE=0 ARM=1 RUN=2 STOP=3)
//
// Output handshake: a beat transfers on a rising clk edge where
// m_valid & m_ready. m_data/m_last stay stable while m_valid is high and
// m_ready is low. A transfer in the same cycle frees the register for a new
// sample.
// ---------------------------------------------------------------------------
module adc_acq_ctrl #(
    parameter int CNT_W          = 24,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_init,
    input  logic             acq_start,
    input  logic             acq_abort,
    input  logic [CNT_W-1:0] acq_len,
    input  logic             acq_test,
    output logic             adc_start,
    output logic             adc_test,
    input  logic [15:0]      adc_data_in,
    input  logic             adc_data_en_in,
    output logic [15:0]      m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_overflow,
    output logic [CNT_W-1:0] sample_count,
    output logic [1:0]       state_dbg
);

    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int IDL_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [IDL_W-1:0] IDLE_LAST   = IDL_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SET_W-1:0]   settle_cnt;
    logic [IDL_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   len_q;

    logic accept;
    logic reg_free;
    logic take;
    logic overflow_ev;
    logic final_ev;
    logic abort_ev;
    logic init_lost;
    logic timeout_ev;
    logic settle_done;
    logic stop_exit;

    assign adc_start = (state == ST_ARM) || (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Next-state and event decode
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        take        = 1'b0;
        overflow_ev = 1'b0;
        final_ev    = 1'b0;
        abort_ev    = 1'b0;
        init_lost   = 1'b0;
        timeout_ev  = 1'b0;
        stop_exit   = 1'b0;
        reg_free    = !m_valid || m_ready;
        settle_done = (settle_cnt == SETTLE_LAST);

        case (state)
            ST_IDLE: begin
                accept = acq_start && adc_init && !acq_abort;
                if (accept) state_next = ST_ARM;
            end
            ST_ARM: begin
                init_lost = !adc_init;
                abort_ev  = acq_abort || init_lost;
                if (abort_ev)         state_next = ST_STOP;
                else if (settle_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                init_lost   = !adc_init;
                abort_ev    = acq_abort || init_lost;
                take        = adc_data_en_in && reg_free;
                overflow_ev = adc_data_en_in && !reg_free;
                // The final sample is forwarded with m_last even if an abort
                // arrives in the same cycle.
                final_ev    = take && (len_q != '0) &&
                              (sample_count == len_q - CNT_W'(1));
                timeout_ev  = !adc_data_en_in && (idle_cnt == IDLE_LAST);
                if (final_ev || abort_ev || timeout_ev) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Leave only after the settle window and once any pending beat
                // has been taken downstream.
                stop_exit = settle_done && !m_valid;
                if (stop_exit) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt   <= '0;
            idle_cnt     <= '0;
            len_q        <= '0;
            adc_test     <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            sample_count <= '0;
        end else begin
            done <= stop_exit;

            // Settle counter restarts on every state change, so it times
            // both the ARM window and the STOP window.
            if (state != state_next)  settle_cnt <= '0;
            else if (!settle_done)    settle_cnt <= settle_cnt + SET_W'(1);

            // Any sample, including an overflow drop, proves the ADC is alive.
            if ((state != ST_RUN) || adc_data_en_in) idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST)          idle_cnt <= idle_cnt + IDL_W'(1);

            if (accept) begin
                len_q        <= acq_len;
                adc_test     <= acq_test;
                sample_count <= '0;
                err_timeout  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (stop_exit) adc_test <= 1'b0;

            if (timeout_ev || init_lost) err_timeout  <= 1'b1;
            if (overflow_ev)             err_overflow <= 1'b1;

            if (take) begin
                m_data       <= adc_data_in;
                m_valid      <= 1'b1;
                m_last       <= final_ev;
                sample_count <= sample_count + CNT_W'(1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/adc_acq_ctrl.md
Name: adc_acq_ctrl

Overview:
Acquisition sequencer for the AD9265 capture path. Gates ADC capture through adc_start/adc_test, discards samples during the settle window, and forwards exactly acq_len samples (or runs continuously) to a valid/ready stream with a last marker. Also reports done, timeout and overflow status to the host register block. Sits between the host command/register logic and the ADC top interface, all in the clk domain.

Parameters:
CNT_W, 24, width of acq_len and sample counter
SETTLE_CYCLES, 64, clk cycles after adc_start rises (and after it falls) during which samples are discarded
TIMEOUT_CYCLES, 4096, clk cycles without adc_data_en_in in RUN before err_timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
adc_init  in  1  ADC SPI configuration complete
acq_start  in  1  single-cycle start request
acq_abort  in  1  single-cycle abort request
acq_len  in  CNT_W  samples per capture, sampled on accepted acq_start; 0 = continuous
acq_test  in  1  test-pattern mode, sampled on accepted acq_start
adc_start  out  1  capture enable to ADC interface
adc_test  out  1  test-pattern select to ADC interface
adc_data_in  in  16  sample from ADC interface FIFO
adc_data_en_in  in  1  sample valid
m_data  out  16  output sample
m_valid  out  1  output valid
m_last  out  1  final sample of capture
m_ready  in  1  downstream ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on return to IDLE after STOP
err_timeout  out  1  sticky; cleared on next accepted acq_start
err_overflow  out  1  sticky; cleared on next accepted acq_start
sample_count  out  CNT_W  samples forwarded in current/last capture

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; sticky flags 0.
- States: IDLE, ARM, RUN, STOP.
- IDLE: acq_start accepted only when adc_init=1 and acq_abort=0 in the same cycle; otherwise it is ignored.
  - On acceptance: latch acq_len and acq_test, clear sample_count and sticky flags, go to ARM.
  - adc_start=1 and adc_test=latched value from the next cycle.
- ARM: adc_start=1; count SETTLE_CYCLES; every adc_data_en_in is dropped; then go to RUN.
- RUN: each adc_data_en_in loads the output register; m_valid rises the next cycle; sample_count increments.
  - When sample_count reaches latched len (len != 0), that sample carries m_last=1 and the state goes to STOP.
  - Idle counter resets on each adc_data_en_in; reaching TIMEOUT_CYCLES sets err_timeout and goes to STOP with no m_last.
- Output register: m_valid held until m_ready. If adc_data_en_in arrives while m_valid=1 and m_ready=0:
  - the new sample is dropped and not counted;
  - err_overflow is set;
  - capture continues.
  - A same-cycle handshake (m_valid & m_ready) frees the register, so no overflow.
- STOP: adc_start=0; samples are discarded for SETTLE_CYCLES. Wait for any pending m_valid to handshake. Then pulse done, clear adc_test, go to IDLE.
- acq_abort in ARM/RUN goes to STOP; no m_last is generated. If abort coincides with the final sample, the sample is forwarded with m_last=1 (final sample wins). acq_abort in IDLE or STOP is ignored.
- adc_init falling in ARM/RUN is treated as abort and also sets err_timeout.
- acq_start while busy is ignored; latched len/test are unchanged.
- Counter wrap: in continuous mode, sample_count wraps 2^CNT_W-1 to 0 silently.
- Reset mid-operation returns to IDLE within 1 cycle: adc_start=0, m_valid=0, no done pulse.

Test Plan:
- Normal capture: adc_init=1, acq_len=8, m_ready=1, ADC stream 0x1000.. every cycle → adc_start high 1 cycle after start; first SETTLE_CYCLES samples dropped; exactly 8 beats out, m_last on the 8th; sample_count=8; done pulse; busy low.
- Backpressure: acq_len=4, m_ready=0 for 3 cycles during RUN with samples every cycle → err_overflow=1; dropped samples not counted; still 4 beats total with m_last on the 4th.
- Timeout: acq_len=16, adc_data_en_in stops after 5 samples → err_timeout after 4096 idle cycles; 5 beats, no m_last; done pulses after STOP.
- Abort/last collision: acq_len=3, acq_abort in the same cycle as the 3rd sample → 3rd beat has m_last=1; done; no error flags.
- Gating: acq_start with adc_init=0 → busy stays 0. acq_start+acq_abort same cycle → ignored. Second acq_start during RUN → ignored; len unchanged.
- Continuous + reset: acq_len=0, acq_test=1 → adc_test=1 and beats stream indefinitely. rst mid-RUN → next cycle adc_start=0, m_valid=0, flags 0, no done.
